// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared encodings and helpers for the gshare branch predictor
package bp_pkg;

    localparam logic [1:0] CNT_SNT   = 2'd0;
    localparam logic [1:0] CNT_WNT   = 2'd1;
    localparam logic [1:0] CNT_WT    = 2'd2;
    localparam logic [1:0] CNT_ST    = 2'd3;
    localparam logic [1:0] PHT_RESET = CNT_WNT;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end
        return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

    // Word-aligned PC: the index starts at bit 2, the tag sits directly above it.
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned index_bits);
        return (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned index_bits,
                                           input int unsigned tag_bits);
        return (pc >> (index_bits + 2)) & ((32'd1 << tag_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/bp_btb.sv
// rtl/bp_btb.sv - direct-mapped branch target buffer, one async read port, one write port
module bp_btb #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned TAG_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_idx,
    input  logic [TAG_BITS-1:0]   rd_tag,
    output logic                  rd_hit,
    output logic [31:0]           rd_target,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_target
);

    localparam int unsigned NUM_ENTRIES = 1 << INDEX_BITS;

    logic [NUM_ENTRIES-1:0] valid_q;
    logic [TAG_BITS-1:0]    tag_q    [NUM_ENTRIES];
    logic [31:0]            target_q [NUM_ENTRIES];

    assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_target = target_q[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Payload is only meaningful behind a valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare direction predictor with BTB, history repair and statistics
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned GHR_BITS   = 6,
    parameter int unsigned TAG_BITS   = 8,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pred_valid,
    input  logic [31:0]          pred_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [31:0]          pred_target,
    output logic [GHR_BITS-1:0]  pred_ghr,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic [GHR_BITS-1:0]  upd_ghr,
    input  logic                 upd_taken,
    input  logic [31:0]          upd_target,
    input  logic                 upd_pred_taken,
    input  logic [31:0]          upd_pred_target,
    output logic                 mispredict,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispred_count
);

    localparam int unsigned NUM_ENTRIES = 1 << INDEX_BITS;

    logic [GHR_BITS-1:0]   ghr_q, ghr_d;
    logic [1:0]            pht_q [NUM_ENTRIES];
    logic [CNT_WIDTH-1:0]  branch_q, branch_d;
    logic [CNT_WIDTH-1:0]  mispred_q, mispred_d;

    logic [INDEX_BITS-1:0] pred_idx, upd_idx;
    logic [INDEX_BITS-1:0] pred_pht_idx, upd_pht_idx;
    logic [TAG_BITS-1:0]   pred_tag, upd_tag;
    logic                  btb_hit;
    logic [31:0]           btb_target;

    assign pred_idx     = INDEX_BITS'(pc_index(pred_pc, INDEX_BITS));
    assign upd_idx      = INDEX_BITS'(pc_index(upd_pc, INDEX_BITS));
    assign pred_tag     = TAG_BITS'(pc_tag(pred_pc, INDEX_BITS, TAG_BITS));
    assign upd_tag      = TAG_BITS'(pc_tag(upd_pc, INDEX_BITS, TAG_BITS));
    assign pred_pht_idx = pred_idx ^ INDEX_BITS'(ghr_q);
    assign upd_pht_idx  = upd_idx ^ INDEX_BITS'(upd_ghr);

    bp_btb #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (pred_idx),
        .rd_tag    (pred_tag),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .wr_en     (upd_valid && upd_taken),
        .wr_idx    (upd_idx),
        .wr_tag    (upd_tag),
        .wr_target (upd_target)
    );

    assign pred_hit    = btb_hit;
    assign pred_taken  = btb_hit && pht_q[pred_pht_idx][1];
    assign pred_target = pred_taken ? btb_target : pred_pc + 32'd4;
    assign pred_ghr    = ghr_q;

    assign mispredict = upd_valid && ((upd_taken != upd_pred_taken) ||
                        (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

    // Repair rebuilds history from the snapshot the branch saw at fetch, overriding any speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (mispredict) begin
            ghr_d = {upd_ghr[GHR_BITS-2:0], upd_taken};
        end else if (pred_valid && pred_hit) begin
            ghr_d = {ghr_q[GHR_BITS-2:0], pred_taken};
        end
    end

    always_comb begin
        branch_d  = branch_q;
        mispred_d = mispred_q;
        if (upd_valid && (branch_q != '1)) begin
            branch_d = branch_q + 1'b1;
        end
        if (mispredict && (mispred_q != '1)) begin
            mispred_d = mispred_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q     <= '0;
            branch_q  <= '0;
            mispred_q <= '0;
        end else begin
            ghr_q     <= ghr_d;
            branch_q  <= branch_d;
            mispred_q <= mispred_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                pht_q[i] <= PHT_RESET;
            end
        end else if (upd_valid) begin
            pht_q[upd_pht_idx] <= sat_update(pht_q[upd_pht_idx], upd_taken);
        end
    end

    assign branch_count  = branch_q;
    assign mispred_count = mispred_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - directed self-checking bench for gshare_predictor
module tb_gshare_predictor;

    logic        clk;
    logic        rst_n;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic [5:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [5:0]  upd_ghr;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] branch_count, mispred_count;

    logic        s_hit, s_taken, s_mispredict;
    logic [31:0] s_target;
    logic [5:0]  s_ghr;
    logic [3:0]  s_branch_count, s_mispred_count;

    int n_cmp = 0;
    int n_err = 0;

    gshare_predictor u_dut (
        .clk(clk), .rst_n(rst_n), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .pred_ghr(pred_ghr), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict),
        .branch_count(branch_count), .mispred_count(mispred_count)
    );

    gshare_predictor #(.CNT_WIDTH(4)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_hit(s_hit), .pred_taken(s_taken), .pred_target(s_target),
        .pred_ghr(s_ghr), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(s_mispredict),
        .branch_count(s_branch_count), .mispred_count(s_mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        pred_valid      = 1'b0;
        upd_valid       = 1'b0;
        upd_pc          = 32'h0;
        upd_ghr         = 6'h0;
        upd_taken       = 1'b0;
        upd_target      = 32'h0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h0;
    endtask

    task automatic set_update(input logic [31:0] pc, input logic [5:0] ghr, input logic taken,
                              input logic [31:0] target, input logic ptaken, input logic [31:0] ptarget);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_ghr         = ghr;
        upd_taken       = taken;
        upd_target      = target;
        upd_pred_taken  = ptaken;
        upd_pred_target = ptarget;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        pred_pc = 32'h100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit got %b want 0", pred_hit); end
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken got %b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h104) begin n_err++; $display("FAIL reset_target got %h want 00000104", pred_target); end
        n_cmp++; if (pred_ghr !== 6'd0) begin n_err++; $display("FAIL reset_ghr got %b want 000000", pred_ghr); end
        n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL reset_mispredict got %b want 0", mispredict); end
        n_cmp++; if (branch_count !== 32'd0) begin n_err++; $display("FAIL reset_branch_count got %0d want 0", branch_count); end
        n_cmp++; if (mispred_count !== 32'd0) begin n_err++; $display("FAIL reset_mispred_count got %0d want 0", mispred_count); end
    endtask

    task automatic test_first_update();
        @(negedge clk);
        set_update(32'h100, 6'd0, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL first_mispredict got %b want 1", mispredict); end
        @(negedge clk);
        idle_inputs();
        pred_pc = 32'h100;
        #1;
        n_cmp++; if (pred_ghr !== 6'b000001) begin n_err++; $display("FAIL first_ghr got %b want 000001", pred_ghr); end
        n_cmp++; if (branch_count !== 32'd1) begin n_err++; $display("FAIL first_branch_count got %0d want 1", branch_count); end
        n_cmp++; if (mispred_count !== 32'd1) begin n_err++; $display("FAIL first_mispred_count got %0d want 1", mispred_count); end
        n_cmp++; if (pred_hit !== 1'b1) begin n_err++; $display("FAIL first_hit got %b want 1", pred_hit); end
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL first_taken got %b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h104) begin n_err++; $display("FAIL first_target got %h want 00000104", pred_target); end
    endtask

    task automatic test_pht_training();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_update(32'h100, 6'd0, 1'b1, 32'h80, 1'b1, 32'h80);
            #1;
            n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL train_mispredict[%0d] got %b want 0", i, mispredict); end
        end
        @(negedge clk);
        set_update(32'h100, 6'd0, 1'b0, 32'h0, 1'b1, 32'h80);
        #1;
        n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL train_nt_mispredict got %b want 1", mispredict); end
        @(negedge clk);
        idle_inputs();
        pred_pc = 32'h100;
        #1;
        n_cmp++; if (pred_ghr !== 6'd0) begin n_err++; $display("FAIL train_ghr got %b want 000000", pred_ghr); end
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL train_taken got %b want 1", pred_taken); end
        n_cmp++; if (pred_target !== 32'h80) begin n_err++; $display("FAIL train_target got %h want 00000080", pred_target); end
        n_cmp++; if (branch_count !== 32'd5) begin n_err++; $display("FAIL train_branch_count got %0d want 5", branch_count); end
        n_cmp++; if (mispred_count !== 32'd2) begin n_err++; $display("FAIL train_mispred_count got %0d want 2", mispred_count); end
    endtask

    task automatic test_repair_priority();
        @(negedge clk);
        pred_valid = 1'b1;
        pred_pc    = 32'h100;
        set_update(32'h200, 6'b101010, 1'b0, 32'h0, 1'b1, 32'h80);
        #1;
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL repair_lookup_taken got %b want 1", pred_taken); end
        n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL repair_mispredict got %b want 1", mispredict); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (pred_ghr !== 6'b010100) begin n_err++; $display("FAIL repair_ghr got %b want 010100", pred_ghr); end
    endtask

    task automatic test_spec_shift();
        @(negedge clk);
        pred_valid = 1'b1;
        pred_pc    = 32'h100;
        #1;
        n_cmp++; if (pred_hit !== 1'b1) begin n_err++; $display("FAIL shift_hit got %b want 1", pred_hit); end
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL shift_taken got %b want 0", pred_taken); end
        @(negedge clk);
        pred_pc = 32'h300;
        #1;
        n_cmp++; if (pred_ghr !== 6'b101000) begin n_err++; $display("FAIL shift_ghr got %b want 101000", pred_ghr); end
        n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL shift_tag_miss_hit got %b want 0", pred_hit); end
        n_cmp++; if (pred_target !== 32'h304) begin n_err++; $display("FAIL shift_tag_miss_target got %h want 00000304", pred_target); end
        @(negedge clk);
        pred_valid = 1'b0;
        #1;
        n_cmp++; if (pred_ghr !== 6'b101000) begin n_err++; $display("FAIL shift_miss_ghr got %b want 101000", pred_ghr); end
    endtask

    task automatic test_target_mispredict();
        @(negedge clk);
        set_update(32'h100, 6'd0, 1'b1, 32'h90, 1'b1, 32'h80);
        upd_valid = 1'b0;
        #1;
        n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL tgt_idle_mispredict got %b want 0", mispredict); end
        upd_valid = 1'b1;
        #1;
        n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL tgt_mispredict got %b want 1", mispredict); end
        @(negedge clk);
        set_update(32'h100, 6'b100000, 1'b0, 32'h0, 1'b1, 32'h90);
        @(negedge clk);
        idle_inputs();
        pred_pc = 32'h100;
        #1;
        n_cmp++; if (pred_ghr !== 6'd0) begin n_err++; $display("FAIL tgt_ghr got %b want 000000", pred_ghr); end
        n_cmp++; if (pred_target !== 32'h90) begin n_err++; $display("FAIL tgt_overwrite_target got %h want 00000090", pred_target); end
        n_cmp++; if (mispred_count !== 32'd5) begin n_err++; $display("FAIL tgt_mispred_count got %0d want 5", mispred_count); end
        pred_pc = 32'hFFFF_FFFC;
        #1;
        n_cmp++; if (pred_target !== 32'h0) begin n_err++; $display("FAIL wrap_target got %h want 00000000", pred_target); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        pred_pc = 32'h100;
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL areset_hit got %b want 0", pred_hit); end
        n_cmp++; if (branch_count !== 32'd0) begin n_err++; $display("FAIL areset_branch_count got %0d want 0", branch_count); end
        n_cmp++; if (pred_ghr !== 6'd0) begin n_err++; $display("FAIL areset_ghr got %b want 000000", pred_ghr); end
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_stat_saturation();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            set_update(32'h400, 6'd0, 1'b1, 32'h10, 1'b0, 32'h404);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++; if (s_branch_count !== 4'd15) begin n_err++; $display("FAIL sat_branch_count got %0d want 15", s_branch_count); end
        n_cmp++; if (s_mispred_count !== 4'd15) begin n_err++; $display("FAIL sat_mispred_count got %0d want 15", s_mispred_count); end
        n_cmp++; if (branch_count !== 32'd20) begin n_err++; $display("FAIL wide_branch_count got %0d want 20", branch_count); end
        n_cmp++; if (mispred_count !== 32'd20) begin n_err++; $display("FAIL wide_mispred_count got %0d want 20", mispred_count); end
    endtask

    initial begin
        test_reset();
        test_first_update();
        test_pht_training();
        test_repair_priority();
        test_spec_shift();
        test_target_mispredict();
        test_async_reset();
        test_stat_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
